cntr_updown_n: RTL and testbench
================================

# cntr_updown_n

Parametrised synchronous up/down counter. It generalises the team's fixed 8-bit free-running counter with:
- configurable width and terminal value;
- direction control, enable, synchronous clear and parallel load;
- wrap or saturate mode;
- terminal-count pulse and sticky overflow/underflow flags.

It serves as the general-purpose event/timer counter for datapath and control blocks.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥2).
- MAX_VAL, 2**WIDTH-1, terminal value; count range is 0..MAX_VAL (1 ≤ MAX_VAL ≤ 2**WIDTH-1).
- PRESCALE, 4, enable divider ratio (≥1); used only when CNTR_PRESCALE_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  load value.
- sat_mode  in  1  1 = saturate at bounds, 0 = wrap.
- flag_clr  in  1  clears ovf and unf.
- count  out  WIDTH  current count (registered).
- tc  out  1  one-cycle pulse on a boundary step.
- ovf  out  1  sticky: an up step was attempted at MAX_VAL.
- unf  out  1  sticky: a down step was attempted at 0.

## Operation
- Reset: count=0, tc=0, ovf=0, unf=0, prescaler=0.
- Per-cycle priority: clr > load > step > hold.
- clr: count←0, tc←0, prescaler←0. Flags are not affected by clr.
- load: count←min(load_val, MAX_VAL), tc←0, prescaler←0.
- Step condition: en=1, no clr/load, and a prescale tick (always true without the macro).
- Up step, count<MAX_VAL: count+1.
- Up step, count=MAX_VAL:
  - wrap mode: count←0;
  - saturate mode: count holds MAX_VAL;
  - both modes: tc←1, ovf←1.
- Down step, count>0: count-1.
- Down step, count=0:
  - wrap mode: count←MAX_VAL;
  - saturate mode: count holds 0;
  - both modes: tc←1, unf←1.
- tc=0 in every cycle without a boundary step.
- Arithmetic is WIDTH bits; no intermediate wider than WIDTH+1. count never exceeds MAX_VAL.
- flag_clr clears ovf and unf. If flag_clr coincides with a new boundary step, set wins and the flag reads 1.
- up and sat_mode are sampled each cycle. Changing them mid-count takes effect on the next step; no other state is disturbed.

## Timing
- All outputs are registered.
- A step, load or clr in cycle N is visible on count after edge N+1.
- tc is asserted for exactly the cycle following the boundary edge, aligned with the wrapped or held count.
- ovf and unf rise on the same edge as tc and stay high until flag_clr or rst.
- rst asserted mid-count forces all outputs to their reset values immediately, independent of clk. Deassertion is synchronised by the integrator. The first step can occur at the first edge after deassertion.

## Configuration
- CNTR_PRESCALE_EN defined:
  - an internal prescaler of clog2(PRESCALE) bits (1 bit minimum) counts en cycles;
  - a step occurs only on an en cycle where the prescaler equals PRESCALE-1, after which the prescaler returns to 0;
  - en=0 freezes the prescaler;
  - clr/load reset it to 0;
  - PRESCALE=1 behaves as an undivided counter.
- CNTR_PRESCALE_EN undefined: no prescaler logic; every en cycle is a step; PRESCALE is ignored.

## Test plan
- WIDTH=8, MAX_VAL=9, wrap, up, en=1 from reset → count 0,1,…,9,0. tc high only in the cycle count shows 0 after 9. ovf=1 thereafter.
- Same config, saturate, up for 12 enabled cycles → count sticks at 9. tc pulses on each attempted step at 9. ovf=1.
- Down from load_val=0, wrap → count 9. tc=1, unf=1. flag_clr together with another underflow → unf stays 1. flag_clr alone → unf=0.
- load_val=200 with MAX_VAL=9 → count 9. Simultaneous clr, load and en → count 0.
- rst pulsed asynchronously between edges while count=5 → count, tc, ovf and unf are 0 immediately; counting resumes from 0.
- CNTR_PRESCALE_EN, PRESCALE=4, up, en toggling 1,1,0,1,1 → count increments once, after the 4th enabled cycle.

Source files
------------

// File: rtl/cntr_updown_n.sv
// Parametrised up/down counter with wrap/saturate modes, terminal-count pulse and sticky flags.
// Optional enable prescaler is built only when CNTR_PRESCALE_EN is defined.
module cntr_updown_n #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX = MAX_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] count_reg, count_next;
  logic             tc_reg, tc_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;
  logic             tick;
  logic             step;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_clamped;

`ifdef CNTR_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_reg, pre_next;

  assign tick = (pre_reg == PRE_LAST);

  // The prescaler only advances on enabled cycles that are not overridden by clr/load.
  always_comb begin
    pre_next = pre_reg;
    if (clr || load)
      pre_next = '0;
    else if (en)
      pre_next = tick ? '0 : pre_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pre_reg <= '0;
    else
      pre_reg <= pre_next;
  end
`else
  // Without the prescaler every enabled cycle steps; PRESCALE is otherwise unused.
  assign tick = (PRESCALE >= 1);
`endif

  assign step         = en && tick;
  assign at_max       = (count_reg == MAX);
  assign at_zero      = (count_reg == '0);
  assign load_clamped = (load_val > MAX) ? MAX : load_val;

  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    ovf_next   = ovf_reg && !flag_clr;
    unf_next   = unf_reg && !flag_clr;
    if (clr) begin
      count_next = '0;
    end else if (load) begin
      count_next = load_clamped;
    end else if (step) begin
      if (up) begin
        if (at_max) begin
          tc_next    = 1'b1;
          ovf_next   = 1'b1;
          count_next = sat_mode ? MAX : '0;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end else begin
        if (at_zero) begin
          tc_next    = 1'b1;
          unf_next   = 1'b1;
          count_next = sat_mode ? '0 : MAX;
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      tc_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  assign count = count_reg;
  assign tc    = tc_reg;
  assign ovf   = ovf_reg;
  assign unf   = unf_reg;

endmodule

// File: tb/tb_cntr_updown_n.sv
// Self-checking bench for cntr_updown_n (WIDTH=8, MAX_VAL=9) against a behavioural model.
// Works with or without CNTR_PRESCALE_EN; prescaler scenario runs only when it is defined.
module tb_cntr_updown_n;

  localparam int WIDTH    = 8;
  localparam int MAX_VAL  = 9;
  localparam int PRESCALE = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             en = 1'b0;
  logic             up = 1'b1;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             sat_mode = 1'b0;
  logic             flag_clr = 1'b0;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
  logic             unf;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_count = 0;
  int m_pre   = 0;
  bit m_tc = 0, m_ovf = 0, m_unf = 0;

  cntr_updown_n #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(load_val), .sat_mode(sat_mode), .flag_clr(flag_clr),
    .count(count), .tc(tc), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH+2:0] obs();
    return {count, tc, ovf, unf};
  endfunction

  function automatic logic [WIDTH+2:0] expv();
    return {WIDTH'(m_count), m_tc, m_ovf, m_unf};
  endfunction

  task automatic model_reset();
    m_count = 0; m_pre = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
  endtask

  // One clock edge of the counter, described from the rules rather than the RTL structure.
  task automatic model_edge();
    bit do_step;
    m_tc = 0;
    if (flag_clr) begin m_ovf = 0; m_unf = 0; end
    if (clr) begin
      m_count = 0; m_pre = 0;
    end else if (load) begin
      m_count = (int'(load_val) > MAX_VAL) ? MAX_VAL : int'(load_val);
      m_pre = 0;
    end else if (en) begin
      do_step = 1;
`ifdef CNTR_PRESCALE_EN
      if (m_pre == PRESCALE - 1) m_pre = 0;
      else begin m_pre++; do_step = 0; end
`endif
      if (do_step) begin
        if (up) begin
          if (m_count == MAX_VAL) begin m_tc = 1; m_ovf = 1; end
          if (!(sat_mode && m_count == MAX_VAL)) m_count = (m_count + 1) % (MAX_VAL + 1);
        end else begin
          if (m_count == 0) begin m_tc = 1; m_unf = 1; end
          if (!(sat_mode && m_count == 0)) m_count = (m_count + MAX_VAL) % (MAX_VAL + 1);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    clr = 0; en = 0; load = 0; flag_clr = 0; up = 1; sat_mode = 0; load_val = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs(), '0);
    end
    rst = 0;
  endtask

  task automatic test_wrap_up();
    idle_inputs();
    en = 1; up = 1; sat_mode = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL wrap_up[%0d]: got %h expected %h", i, obs(), expv());
      end
      $display("wrap_up cycle %0d count=%0d tc=%0b ovf=%0b", i, count, tc, ovf);
    end
`ifndef CNTR_PRESCALE_EN
    checks++;
    if ({count, tc, ovf} !== {8'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wrap_up_end: got count=%0d tc=%0b ovf=%0b expected 0 1 1", count, tc, ovf);
    end
`endif
  endtask

  task automatic test_saturate();
    idle_inputs();
    en = 1; up = 1; sat_mode = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL saturate[%0d]: got %h expected %h", i, obs(), expv());
      end
      $display("saturate cycle %0d count=%0d tc=%0b ovf=%0b", i, count, tc, ovf);
    end
`ifndef CNTR_PRESCALE_EN
    checks++;
    if ({count, tc, ovf} !== {8'd9, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL saturate_end: got count=%0d tc=%0b ovf=%0b expected 9 1 1", count, tc, ovf);
    end
`endif
  endtask

  task automatic test_async_reset();
    idle_inputs();
    load = 1; load_val = 8'd5;
    tick();
    load = 0;
    tick();
    checks++;
    if (count !== 8'd5) begin
      errors++;
      $display("FAIL async_reset_pre: got count=%0d expected 5", count);
    end
    #2 rst = 1;
    #1;
    model_reset();
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", obs(), '0);
    end
    $display("async_reset count=%0d tc=%0b ovf=%0b unf=%0b", count, tc, ovf, unf);
    rst = 0;
    en = 1; up = 1;
    tick();
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL async_reset_resume: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_underflow();
    logic [WIDTH+2:0] exp_now;
    idle_inputs();
    // Ordered phases: load 0, step down, reload 0, step down with flag_clr, flag_clr alone
    for (int ph = 0; ph < 5; ph++) begin
      idle_inputs();
      case (ph)
        0, 2: begin load = 1; load_val = 8'd0; end
        1:    begin en = 1; up = 0; end
        3:    begin en = 1; up = 0; flag_clr = 1; end
        default: flag_clr = 1;
      endcase
      tick();
      exp_now = expv();
      checks++;
      if (obs() !== exp_now) begin
        errors++;
        $display("FAIL underflow[%0d]: got %h expected %h", ph, obs(), exp_now);
      end
      $display("underflow phase %0d count=%0d tc=%0b unf=%0b", ph, count, tc, unf);
`ifndef CNTR_PRESCALE_EN
      if (ph == 1 || ph == 3 || ph == 4) begin
        checks++;
        if ({tc, unf} !== ((ph == 4) ? 2'b00 : 2'b11) || (ph == 1 && count !== 8'd9)) begin
          errors++;
          $display("FAIL underflow_rule[%0d]: got count=%0d tc=%0b unf=%0b", ph, count, tc, unf);
        end
      end
`endif
    end
  endtask

  task automatic test_load_clamp();
    idle_inputs();
    load = 1; load_val = 8'd200;
    tick();
    checks++;
    if (count !== 8'd9 || obs() !== expv()) begin
      errors++;
      $display("FAIL load_clamp: got count=%0d expected 9", count);
    end
    $display("load_clamp count=%0d", count);
    clr = 1; load = 1; en = 1; load_val = 8'd3;
    tick();
    checks++;
    if (count !== 8'd0 || obs() !== expv()) begin
      errors++;
      $display("FAIL clr_priority: got count=%0d expected 0", count);
    end
    $display("clr_priority count=%0d", count);
  endtask

`ifdef CNTR_PRESCALE_EN
  task automatic test_prescale();
    bit pattern [5] = '{1, 1, 0, 1, 1};
    idle_inputs();
    clr = 1;
    tick();
    clr = 0; up = 1;
    for (int i = 0; i < 5; i++) begin
      en = pattern[i];
      tick();
      checks++;
      if (count !== ((i == 4) ? 8'd1 : 8'd0) || obs() !== expv()) begin
        errors++;
        $display("FAIL prescale[%0d]: got count=%0d expected %0d", i, count, (i == 4) ? 1 : 0);
      end
      $display("prescale cycle %0d en=%0b count=%0d", i, en, count);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      clr      = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = WIDTH'($urandom_range(0, 255));
      en       = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1);
      sat_mode = $urandom_range(0, 1);
      flag_clr = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs(), expv());
      end
    end
    $display("random 300 cycles done");
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_saturate();
    test_async_reset();
    test_underflow();
    test_load_clamp();
`ifdef CNTR_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
